// File: rtl/pipe_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types for the elastic pipeline stage register (pipe_skid_reg).
//   - skid_state_e : occupancy of the stage (EMPTY / BUSY / FULL)
//   - STATS_CNT_W  : width of the optional stall/bubble statistics counters
//   - per-stage control structs that instantiating stages cast to/from the
//     generic in_ctrl/out_ctrl vector (all CTRL_W = 8 bits wide)
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no entry held
    BUSY  = 2'd1,  // main register valid
    FULL  = 2'd2   // main and skid registers valid
  } skid_state_e;

  localparam int STATS_CNT_W = 32;

  typedef struct packed {
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic       call;
    logic       reg_dst;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_src;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic       call;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] rsvd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic       call;
    logic [3:0] rsvd;
  } mem_wb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_reg_stat_cnt.sv
// ---------------------------------------------------------------------------
// pipe_stat_cnt
//   Saturating event counter with enable; sticks at all-ones.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset (count -> 0)
//     en_i   in   count this cycle
//     cnt_o  out  current count
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stat_cnt
  import pipe_pkg::*;
#(
  parameter int W = STATS_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Elastic valid/ready pipeline stage with a 2-entry skid buffer. The main
//   register drives the outputs directly; the skid register absorbs the one
//   entry accepted while downstream stalls, so in_ready can be registered
//   and still sustain one entry per cycle. Synchronous flush empties the
//   stage and zeroes control so a killed entry has no side effects.
//   Ports:
//     clk, rst_n (async, active-low), flush (synchronous kill)
//     in_valid/in_ready/in_data/in_ctrl     upstream handshake + payload
//     out_valid/out_ready/out_data/out_ctrl downstream handshake + payload
//     stall_cnt/bubble_cnt                  only with PIPE_SKID_STATS_EN
//   Optional feature macro: PIPE_SKID_STATS_EN
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                CTRL_W     = 8,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] stall_cnt,
  output logic [STATS_CNT_W-1:0] bubble_cnt
`endif
);

  skid_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Any entry accepted this cycle is dropped along with held ones.
      state_d     = EMPTY;
      main_data_d = RESET_DATA;
      main_ctrl_d = '0;
      skid_data_d = RESET_DATA;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = BUSY;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (out_fire) begin
            state_d     = BUSY;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= RESET_DATA;
      main_ctrl_q <= '0;
      skid_data_q <= RESET_DATA;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = main_data_q;
  assign out_ctrl = main_ctrl_q;

`ifdef PIPE_SKID_STATS_EN
  logic stall_en;
  logic bubble_en;

  assign stall_en  = out_valid & ~out_ready;
  assign bubble_en = ~out_valid & out_ready;

  pipe_stat_cnt #(.W(STATS_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );

  pipe_stat_cnt #(.W(STATS_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bubble_en),
    .cnt_o (bubble_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Self-checking bench for pipe_skid_reg. The reference model is a 2-deep
//   FIFO queue plus a "last presented" register for the output payload.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .RESET_DATA('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          q[$];
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ctrl;
  logic [31:0]   m_stall;
  logic [31:0]   m_bubble;

  function automatic void model_clear();
    q.delete();
    m_data   = '0;
    m_ctrl   = '0;
    m_stall  = '0;
    m_bubble = '0;
  endfunction

  function automatic void model_step();
    bit mv;
    bit mir;
    mv  = (q.size() > 0);
    mir = (q.size() < 2);
    if (mv && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (!mv && out_ready && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 1;
    if (flush) begin
      q.delete();
      m_data = '0;
      m_ctrl = '0;
    end else begin
      if (mv && out_ready) void'(q.pop_front());
      if (in_valid && mir) q.push_back({in_ctrl, in_data});
      if (q.size() > 0) begin
        m_data = q[0].d;
        m_ctrl = q[0].c;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
  endtask

  // Advance one clock; inputs were set before, outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_ctrl !== 8'h0) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d[3];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1, exp_d[i], 8'(i + 1), 1, 0);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        failures++; $display("FAIL stream_%0d got v=%0b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d[i]);
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready_%0d got=%0b exp=1", i, in_ready); end
    end
    drive(0, '0, '0, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_stall_full();
    drive(1, 32'hA, 8'h0A, 0, 0); tick();
    drive(1, 32'hB, 8'h0B, 0, 0); tick();
    drive(0, '0, '0, 0, 0); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin
      failures++; $display("FAIL full_hold got v=%0b d=%h exp v=1 d=a", out_valid, out_data);
    end
    // A is taken at the next edge, B moves up from the skid register.
    drive(0, '0, '0, 1, 0); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hB || out_ctrl !== 8'h0B) begin
      failures++; $display("FAIL full_drain_b got v=%0b d=%h c=%h exp v=1 d=b c=0b", out_valid, out_data, out_ctrl);
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1, 32'hDEAD_BEEF, 8'hFF, 0, 0); tick();
    drive(1, 32'hCAFE_F00D, 8'hFF, 0, 0); tick();
    drive(0, '0, '0, 0, 0);
    checks++; if (out_ctrl !== 8'hFF || in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_setup got c=%h r=%0b exp c=ff r=0", out_ctrl, in_ready);
    end
    drive(0, '0, '0, 0, 1); tick();
    drive(0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_kill got v=%0b c=%h d=%h r=%0b exp v=0 c=0 d=0 r=1",
                           out_valid, out_ctrl, out_data, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_emerge_%0d got=%0b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_flush_with_fire();
    drive(1, 32'hD, 8'h5A, 1, 1); tick();
    drive(0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h0) begin
      failures++; $display("FAIL flush_fire got v=%0b c=%h exp v=0 c=0", out_valid, out_ctrl);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_fire_later got=%0b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h44, 8'h44, 0, 0); tick();
    drive(1, 32'h55, 8'h55, 0, 0);
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_ctrl !== 8'h0) begin
      failures++; $display("FAIL async_reset got v=%0b r=%0b d=%h c=%h exp v=0 r=1 d=0 c=0",
                           out_valid, in_ready, out_data, out_ctrl);
    end
    @(negedge clk);
    drive(0, '0, '0, 1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 32'h66, 8'h66, 1, 0); tick();
    drive(0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h66) begin
      failures++; $display("FAIL post_reset_latency got v=%0b d=%h exp v=1 d=66", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
      tick();
      checks++; if (out_valid !== (q.size() > 0)) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, out_valid, (q.size() > 0));
      end
      checks++; if (in_ready !== (q.size() < 2)) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, in_ready, (q.size() < 2));
      end
      checks++; if (out_data !== m_data) begin
        failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, out_data, m_data);
      end
      checks++; if (out_ctrl !== m_ctrl) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", i, out_ctrl, m_ctrl);
      end
`ifdef PIPE_SKID_STATS_EN
      checks++; if (stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
        failures++; $display("FAIL rnd_stats cyc=%0d got s=%0d b=%0d exp s=%0d b=%0d",
                             i, stall_cnt, bubble_cnt, m_stall, m_bubble);
      end
`endif
    end
    drive(0, '0, '0, 1, 0);
    tick(); tick();
  endtask

`ifdef PIPE_SKID_STATS_EN
  task automatic test_stats();
    logic [31:0] s0;
    logic [31:0] b0;
    drive(1, 32'h77, 8'h7, 0, 0); tick();
    drive(0, '0, '0, 0, 0);
    s0 = m_stall;
    repeat (5) tick();
    checks++; if (stall_cnt !== s0 + 32'd5) begin
      failures++; $display("FAIL stats_stall5 got=%0d exp=%0d", stall_cnt, s0 + 32'd5);
    end
    drive(0, '0, '0, 1, 0); tick();
    b0 = m_bubble;
    repeat (3) tick();
    checks++; if (bubble_cnt !== b0 + 32'd3) begin
      failures++; $display("FAIL stats_bubble3 got=%0d exp=%0d", bubble_cnt, b0 + 32'd3);
    end
    dut.u_bubble_cnt.cnt_q = 32'hFFFF_FFFE;
    m_bubble = 32'hFFFF_FFFE;
    repeat (4) tick();
    checks++; if (bubble_cnt !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL stats_saturate got=%h exp=ffffffff", bubble_cnt);
    end
    drive(0, '0, '0, 1, 1); tick();
    drive(0, '0, '0, 1, 0);
    checks++; if (bubble_cnt !== m_bubble) begin
      failures++; $display("FAIL stats_flush_keep got=%h exp=%h", bubble_cnt, m_bubble);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive(0, '0, '0, 0, 0);
    model_clear();
    test_reset();
    test_stream();
    test_stall_full();
    test_flush();
    test_flush_with_fire();
    test_async_reset();
    test_random();
`ifdef PIPE_SKID_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline stage: the successor to the fixed-field stall/flush inter-stage registers.
- Carries a generic DATA_W payload plus a CTRL_W control vector.
- Uses valid/ready handshaking in place of a raw stall input.
- A 2-entry skid buffer gives full throughput with a fully registered in_ready.
- Used between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); synchronous flush kills in-flight contents.

Parameters:
DATA_W, 32, width of datapath payload (ALU result, PC+4, operands packed by the instantiating stage)
CTRL_W, 8, width of control vector (reg_wr, wb_sel, call, reg_dst, ...)
RESET_DATA, '0, value loaded into payload registers on reset and on flush

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage can accept; registered
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control
out_valid  out  1  out_data/out_ctrl hold a valid entry
out_ready  in  1  downstream accepts; low = stall
out_data  out  DATA_W  payload, driven directly from main register
out_ctrl  out  CTRL_W  control, driven directly from main register

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) and skid register.
- State encoding, exported as pkg enum: EMPTY (0 entries), BUSY (main valid), FULL (main+skid valid).
- Reset (async):
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_data = RESET_DATA, out_ctrl = 0; skid data = RESET_DATA, skid ctrl = 0.
- Transitions:
  - EMPTY & in_fire -> BUSY, main <= in.
  - BUSY & in_fire & out_fire -> BUSY, main <= in.
  - BUSY & in_fire & !out_fire -> FULL, skid <= in.
  - BUSY & !in_fire & out_fire -> EMPTY.
  - FULL & out_fire -> BUSY, main <= skid.
  - FULL: in_ready = 0, so no in_fire is possible.
  - No fire -> hold. Payload and control are bit-stable while out_valid & !out_ready.
- in_ready is registered: next value = (next_state != FULL). There is no combinational in->out or out_ready->in_ready path.
- Latency: 1 cycle in_fire -> out_valid when EMPTY. Throughput: 1 entry/cycle while out_ready is held high.
- Ordering: strict FIFO; the skid entry is never overtaken.
- flush (highest priority after reset):
  - Next cycle: state = EMPTY, out_valid = 0, in_ready = 1.
  - Main and skid data <= RESET_DATA; main and skid ctrl <= 0.
  - Any in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream.
- flush with stall (out_ready = 0) still empties the stage.
- Reset asserted mid-transfer: immediate return to reset values; no entry survives.
- Control zeroing on flush guarantees no reg_wr/call side effect from a killed entry.

Optional Feature:
- Macro: PIPE_SKID_STATS_EN.
- Defined: adds output ports stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle !out_valid & out_ready.
  - Both saturate at 32'hFFFF_FFFF, reset to 0 on rst_n, and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg: skid_state_e enum {EMPTY, BUSY, FULL}; constant STATS_CNT_W = 32.
- The package also holds per-stage typedef packed structs (ex_mem_ctrl_t etc.) that callers cast to/from in_ctrl.
- One natural sub-module: pipe_stat_cnt, a saturating 32-bit counter with enable, instantiated twice under PIPE_SKID_STATS_EN.

Test Plan:
- Reset, then stream A=0x11, B=0x22, C=0x33 with out_ready = 1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle after A; in_ready stays 1.
- Send A, B with out_ready = 0 -> state FULL, in_ready = 0, out_data held at A. Raise out_ready -> A then B delivered in order, in_ready returns to 1.
- Stage FULL with out_ctrl = 0xFF; assert flush for 1 cycle -> next cycle out_valid = 0, out_ctrl = 0, out_data = RESET_DATA, in_ready = 1; no entry emerges later.
- in_fire of D coincident with flush -> D discarded, out_valid = 0 the next cycle.
- rst_n pulsed low mid-stream (async, between clock edges) -> outputs reach reset values immediately; first post-reset transfer has 1-cycle latency.
- PIPE_SKID_STATS_EN: hold out_ready = 0 for 5 cycles with a valid entry -> stall_cnt = 5. Idle with out_ready = 1 for 3 cycles -> bubble_cnt = 3. Preload near max -> counter saturates at 32'hFFFF_FFFF.
